// File: rtl/eu_instr_queue.sv
// eu_instr_queue: per-execution-unit in-order instruction queue.
//
// Captures the dispatch-bus slots addressed to this unit (EU_IDX), in slot
// order, into a circular buffer and issues the oldest entry over a
// valid/ready port.
//
// Ports:
//   clk                            clock
//   reset                          synchronous active-high reset
//   flush_i                        synchronous flush (empties the queue)
//   instr_dispatch_i[N]            dispatch-bus entries
//   instr_dispatch_valid_i[N]      per-slot valid
//   dispatched_instr_alloc_euidx_i per-slot target execution unit
//   instr_dispatch_ready_o         room for any N-slot dispatch
//   issue_o / issue_valid_o        oldest queued entry
//   issue_ready_i                  execution unit accepts issue_o
//   count_o                        current occupancy (0..DEPTH)

`ifndef NUM_PARALLEL_INSTR_DISPATCHES
`define NUM_PARALLEL_INSTR_DISPATCHES 2
`endif
`ifndef LOG2_NUM_EXEC_UNITS
`define LOG2_NUM_EXEC_UNITS 2
`endif

module eu_instr_queue #(
  parameter int unsigned EU_IDX                        = 0,
  parameter int unsigned DEPTH                         = 8,
  parameter int unsigned NUM_PARALLEL_INSTR_DISPATCHES = `NUM_PARALLEL_INSTR_DISPATCHES,
  parameter int unsigned LOG2_NUM_EXEC_UNITS           = `LOG2_NUM_EXEC_UNITS,
  parameter type         type_iqueue_entry             = logic [31:0]
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             flush_i,
  input  type_iqueue_entry                 instr_dispatch_i [NUM_PARALLEL_INSTR_DISPATCHES],
  input  logic                             instr_dispatch_valid_i [NUM_PARALLEL_INSTR_DISPATCHES],
  input  logic [LOG2_NUM_EXEC_UNITS-1:0]   dispatched_instr_alloc_euidx_i
                                             [NUM_PARALLEL_INSTR_DISPATCHES],
  output logic                             instr_dispatch_ready_o,
  output type_iqueue_entry                 issue_o,
  output logic                             issue_valid_o,
  input  logic                             issue_ready_i,
  output logic [$clog2(DEPTH):0]           count_o
);

  localparam int unsigned N    = NUM_PARALLEL_INSTR_DISPATCHES;
  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [LOG2_NUM_EXEC_UNITS-1:0] EuIdx = LOG2_NUM_EXEC_UNITS'(EU_IDX);

  type_iqueue_entry mem [DEPTH];

  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;

  logic            match [N];
  logic [PtrW-1:0] slot_addr [N];
  logic [CntW-1:0] push_cnt;
  logic            pop;

  // Ready looks only at registered occupancy so the bus-wide AND of all
  // units' ready never loops back through the dispatch or issue inputs.
  // A pop in the same cycle is deliberately not credited.
  assign instr_dispatch_ready_o = (CntW'(DEPTH) - count_q) >= CntW'(N);

  assign issue_valid_o = (count_q != '0);
  assign issue_o       = mem[rd_ptr_q];
  assign count_o       = count_q;
  assign pop           = issue_valid_o && issue_ready_i;

  // Compact matching slots: each one lands at wr_ptr plus the number of
  // older (lower-index) matching slots, so gaps leave no holes.
  always_comb begin
    push_cnt = '0;
    for (int i = 0; i < N; i++) begin
      match[i]     = instr_dispatch_valid_i[i] &&
                     (dispatched_instr_alloc_euidx_i[i] == EuIdx) &&
                     instr_dispatch_ready_o;
      slot_addr[i] = wr_ptr_q + push_cnt[PtrW-1:0];
      if (match[i]) begin
        push_cnt = push_cnt + CntW'(1);
      end
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (reset || flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // Pointers are DEPTH-modulo by width (DEPTH is a power of two).
      wr_ptr_d = wr_ptr_q + push_cnt[PtrW-1:0];
      rd_ptr_d = rd_ptr_q + PtrW'(pop);
      count_d  = count_q + push_cnt - CntW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    wr_ptr_q <= wr_ptr_d;
    rd_ptr_q <= rd_ptr_d;
    count_q  <= count_d;
  end

  // Storage is not reset; entries outside [rd_ptr, rd_ptr+count) are dead.
  always_ff @(posedge clk) begin
    if (!reset && !flush_i) begin
      for (int i = 0; i < N; i++) begin
        if (match[i]) begin
          mem[slot_addr[i]] <= instr_dispatch_i[i];
        end
      end
    end
  end

endmodule

// File: tb/tb_eu_instr_queue.sv
module tb_eu_instr_queue;

  logic        clk;
  logic        reset;
  logic        flush;
  logic [31:0] disp [2];
  logic        dvld [2];
  logic [1:0]  deu  [2];
  logic        ready;
  logic [31:0] issue;
  logic        issue_valid;
  logic        issue_ready;
  logic [3:0]  count;

  int n_pass;
  int n_total;

  eu_instr_queue #(
    .EU_IDX                        (1),
    .DEPTH                         (8),
    .NUM_PARALLEL_INSTR_DISPATCHES (2),
    .LOG2_NUM_EXEC_UNITS           (2),
    .type_iqueue_entry             (logic [31:0])
  ) dut (
    .clk                            (clk),
    .reset                          (reset),
    .flush_i                        (flush),
    .instr_dispatch_i               (disp),
    .instr_dispatch_valid_i         (dvld),
    .dispatched_instr_alloc_euidx_i (deu),
    .instr_dispatch_ready_o         (ready),
    .issue_o                        (issue),
    .issue_valid_o                  (issue_valid),
    .issue_ready_i                  (issue_ready),
    .count_o                        (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        r;
    logic        f;
    logic        v0;
    logic [1:0]  e0;
    logic [31:0] d0;
    logic        v1;
    logic [1:0]  e1;
    logic [31:0] d1;
    logic        ir;
    int          ec;
    logic        ev;
    logic        er;
    logic [31:0] ed;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
  endtask

  // Drive one cycle of inputs, clock it, then check the registered outputs.
  task automatic cyc(input string name, input logic r, input logic f,
                     input logic v0, input logic [1:0] e0, input logic [31:0] d0,
                     input logic v1, input logic [1:0] e1, input logic [31:0] d1,
                     input logic ir, input int ec, input logic ev, input logic er,
                     input logic [31:0] ed);
    reset = r; flush = f;
    dvld[0] = v0; deu[0] = e0; disp[0] = d0;
    dvld[1] = v1; deu[1] = e1; disp[1] = d1;
    issue_ready = ir;
    @(posedge clk);
    #1;
    chk({name, " count"}, 32'(count), 32'(ec));
    chk({name, " issue_valid"}, 32'(issue_valid), 32'(ev));
    chk({name, " ready"}, 32'(ready), 32'(er));
    if (ev) chk({name, " issue"}, issue, ed);
  endtask

  task automatic add(input logic r, input logic f,
                     input logic v0, input logic [1:0] e0, input logic [31:0] d0,
                     input logic v1, input logic [1:0] e1, input logic [31:0] d1,
                     input logic ir, input int ec, input logic ev, input logic er,
                     input logic [31:0] ed);
    vec_t v;
    v.r = r; v.f = f; v.v0 = v0; v.e0 = e0; v.d0 = d0; v.v1 = v1; v.e1 = e1; v.d1 = d1;
    v.ir = ir; v.ec = ec; v.ev = ev; v.er = er; v.ed = ed;
    tbl.push_back(v);
  endtask

  logic [31:0] drain [7];

  initial begin
    n_pass = 0;
    n_total = 0;
    reset = 1'b1; flush = 1'b0; issue_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      dvld[i] = 1'b0; deu[i] = 2'd0; disp[i] = '0;
    end

    //   r  f  v0 e0 d0     v1 e1 d1     ir cnt ev er issue
    // Reset for two cycles with all slots valid and matching.
    add(1, 0, 1, 1, 'hDEAD, 1, 1, 'hBEEF, 0, 0, 0, 1, 0);
    add(1, 0, 1, 1, 'hDEAD, 1, 1, 'hBEEF, 0, 0, 0, 1, 0);
    // Filtering: A(eu1) B(eu0), then C(eu3) D(eu1) -> queue A, D.
    add(0, 0, 1, 1, 'hA,    1, 0, 'hB,    0, 1, 1, 1, 'hA);
    add(0, 0, 1, 3, 'hC,    1, 1, 'hD,    0, 2, 1, 1, 'hA);
    add(0, 0, 0, 0, 0,      0, 0, 0,      1, 1, 1, 1, 'hD);
    add(0, 0, 0, 0, 0,      0, 0, 0,      1, 0, 0, 1, 0);
    // Pop request on empty queue is ignored.
    add(0, 0, 0, 0, 0,      0, 0, 0,      1, 0, 0, 1, 0);
    // Build count=3 (slot1 matches but is not valid), then push 2 + pop 1.
    add(0, 0, 1, 1, 'hE0,   1, 1, 'hE1,   0, 2, 1, 1, 'hE0);
    add(0, 0, 1, 1, 'hE2,   0, 1, 'hEE,   0, 3, 1, 1, 'hE0);
    add(0, 0, 1, 1, 'hE3,   1, 1, 'hE4,   1, 4, 1, 1, 'hE1);
    add(0, 0, 0, 0, 0,      0, 0, 0,      1, 3, 1, 1, 'hE2);
    add(0, 0, 0, 0, 0,      0, 0, 0,      1, 2, 1, 1, 'hE3);
    add(0, 0, 0, 0, 0,      0, 0, 0,      1, 1, 1, 1, 'hE4);
    add(0, 0, 0, 0, 0,      0, 0, 0,      1, 0, 0, 1, 0);
    // Pointers now at 7: pair X,Y straddles the wrap.
    add(0, 0, 1, 1, 'h58,   1, 1, 'h59,   0, 2, 1, 1, 'h58);
    add(0, 0, 0, 0, 0,      0, 0, 0,      1, 1, 1, 1, 'h59);
    add(0, 0, 0, 0, 0,      0, 0, 0,      1, 0, 0, 1, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      cyc($sformatf("vec%0d", i), tbl[i].r, tbl[i].f, tbl[i].v0, tbl[i].e0, tbl[i].d0,
          tbl[i].v1, tbl[i].e1, tbl[i].d1, tbl[i].ir, tbl[i].ec, tbl[i].ev,
          tbl[i].er, tbl[i].ed);
    end

    // Fill to full, then probe the ready boundary at 7 and 6.
    cyc("fill1", 0, 0, 1, 1, 'hF0, 1, 1, 'hF1, 0, 2, 1, 1, 'hF0);
    cyc("fill2", 0, 0, 1, 1, 'hF2, 1, 1, 'hF3, 0, 4, 1, 1, 'hF0);
    cyc("fill3", 0, 0, 1, 1, 'hF4, 1, 1, 'hF5, 0, 6, 1, 1, 'hF0);
    cyc("fill4", 0, 0, 1, 1, 'hF6, 1, 1, 'hF7, 0, 8, 1, 0, 'hF0);
    cyc("full_a", 0, 0, 1, 1, 'h60, 1, 1, 'h61, 0, 8, 1, 0, 'hF0);
    cyc("full_b", 0, 0, 1, 1, 'h60, 1, 1, 'h61, 0, 8, 1, 0, 'hF0);
    cyc("full_pop", 0, 0, 1, 1, 'h60, 1, 1, 'h61, 1, 7, 1, 0, 'hF1);
    cyc("at7_pop", 0, 0, 1, 1, 'h60, 1, 1, 'h61, 1, 6, 1, 1, 'hF2);
    cyc("single", 0, 0, 1, 0, 'h60, 1, 1, 'h70, 0, 7, 1, 0, 'hF2);
    cyc("at7_hold", 0, 0, 1, 1, 'h60, 1, 1, 'h61, 0, 7, 1, 0, 'hF2);
    drain[0] = 'hF3; drain[1] = 'hF4; drain[2] = 'hF5; drain[3] = 'hF6;
    drain[4] = 'hF7; drain[5] = 'h70; drain[6] = 'h0;
    for (int i = 0; i < 7; i++) begin
      cyc($sformatf("drain%0d", i), 0, 0, 0, 0, 0, 0, 0, 0, 1, 6 - i, (i < 6), 1, drain[i]);
    end

    // Flush at count=5 with a matching dispatch and a pop request.
    cyc("pre1", 0, 0, 1, 1, 'hC0, 1, 1, 'hC1, 0, 2, 1, 1, 'hC0);
    cyc("pre2", 0, 0, 1, 1, 'hC2, 1, 1, 'hC3, 0, 4, 1, 1, 'hC0);
    cyc("pre3", 0, 0, 0, 1, 'hC9, 1, 1, 'hC4, 0, 5, 1, 1, 'hC0);
    cyc("flush", 0, 1, 1, 1, 'hD0, 1, 1, 'hD1, 1, 0, 0, 1, 0);
    cyc("post1", 0, 0, 1, 1, 'hB0, 1, 1, 'hB1, 0, 2, 1, 1, 'hB0);
    cyc("post2", 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 'hB1);
    // Reset mid-stream drops the presented slots.
    cyc("rst_mid", 1, 0, 1, 1, 'hA0, 1, 1, 'hA1, 1, 0, 0, 1, 0);
    cyc("after_rst", 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
